// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the D-stage Tuse/Tnew hazard unit.
// Holds register/timing widths, the scoreboard entry type and small helpers.
package hazard_pkg;

    localparam int REG_AW = 5;
    localparam int T_W    = 2;

    // All-ones Tuse marks an operand the instruction does not read.
    localparam logic [T_W-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic [T_W-1:0]    tnew;
    } sb_entry_t;

    // Width of a forward select: 0 = GRF, k+1 = stage k.
    function automatic int sel_w(input int nstage);
        return (nstage + 1 <= 2) ? 1 : $clog2(nstage + 1);
    endfunction

    // Saturating decrement of a Tnew code.
    function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard bundle between the decoder (master) and hazard unit (slave).
// Master drives D fields (rs/rt/tuse, dst/wen/tnew, md start/use); slave returns stall, selects, md_busy.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3
);
    localparam int SEL_W = sel_w(NSTAGE);

    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [T_W-1:0]    d_tuse_rs;
    logic [T_W-1:0]    d_tuse_rt;
    logic [REG_AW-1:0] d_dst;
    logic              d_wen;
    logic [T_W-1:0]    d_tnew;
    logic              d_md_start;
    logic              d_md_use;
    logic              stall;
    logic [SEL_W-1:0]  fwd_rs_sel;
    logic [SEL_W-1:0]  fwd_rt_sel;
    logic              md_busy;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt,
        output d_dst, d_wen, d_tnew,
        output d_md_start, d_md_use,
        input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt,
        input  d_dst, d_wen, d_tnew,
        input  d_md_start, d_md_use,
        output stall, fwd_rs_sel, fwd_rt_sel, md_busy
    );

endinterface

// File: rtl/hazard_scoreboard_md.sv
// Mul/div busy counter: loads MD_LAT when a start enters E, else counts down.
// Ports: clk_i, reset_i (sync, high), start_i (accepted start), busy_o (count nonzero).
module md_busy_counter #(
    parameter int MD_LAT = 5
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    output logic busy_o
);
    localparam int CW = (MD_LAT + 1 <= 2) ? 1 : $clog2(MD_LAT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = CW'(MD_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit: NSTAGE-deep writer scoreboard (stage 0 = E) plus mul/div busy.
// Ports: clk, reset (sync, high), hz (slave: D fields in; stall, fwd_rs/rt_sel, md_busy out).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int MD_LAT = 5
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  hz
);
    localparam int SEL_W = sel_w(NSTAGE);

    sb_entry_t ent_q [NSTAGE];
    sb_entry_t ent_d [NSTAGE];

    logic [NSTAGE-1:0] m_rs;
    logic [NSTAGE-1:0] m_rt;

    logic             rs_hit;
    logic             rt_hit;
    logic [T_W-1:0]   rs_tnew;
    logic [T_W-1:0]   rt_tnew;
    logic [SEL_W-1:0] rs_k;
    logic [SEL_W-1:0] rt_k;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;
    logic             stall;
    logic             md_busy;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_match
        assign m_rs[k] = ent_q[k].valid &&
                         (ent_q[k].dst == hz.d_rs) &&
                         (hz.d_rs != '0);
        assign m_rt[k] = ent_q[k].valid &&
                         (ent_q[k].dst == hz.d_rt) &&
                         (hz.d_rt != '0);
    end

    // Scan oldest to youngest so the youngest match wins and shadows older ones.
    always_comb begin
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        rs_tnew = '0;
        rt_tnew = '0;
        rs_k    = '0;
        rt_k    = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (m_rs[k]) begin
                rs_hit  = 1'b1;
                rs_tnew = ent_q[k].tnew;
                rs_k    = SEL_W'(k);
            end
            if (m_rt[k]) begin
                rt_hit  = 1'b1;
                rt_tnew = ent_q[k].tnew;
                rt_k    = SEL_W'(k);
            end
        end
    end

    assign stall_rs = rs_hit && (hz.d_tuse_rs != TUSE_NONE) &&
                      (rs_tnew > hz.d_tuse_rs);
    assign stall_rt = rt_hit && (hz.d_tuse_rt != TUSE_NONE) &&
                      (rt_tnew > hz.d_tuse_rt);
    assign stall_md = hz.d_md_use && md_busy;
    assign stall    = stall_rs | stall_rt | stall_md;

    assign hz.stall      = stall;
    assign hz.md_busy    = md_busy;
    assign hz.fwd_rs_sel = (rs_hit && rs_tnew == '0) ? rs_k + 1'b1 : '0;
    assign hz.fwd_rt_sel = (rt_hit && rt_tnew == '0) ? rt_k + 1'b1 : '0;

    // A stalled D slot becomes a bubble in E; $0 or non-writing instrs are stored invalid.
    always_comb begin
        ent_d[0] = '0;
        if (!stall) begin
            ent_d[0].valid = hz.d_wen && (hz.d_dst != '0);
            ent_d[0].dst   = hz.d_dst;
            ent_d[0].tnew  = hz.d_tnew;
        end
        for (int k = 1; k < NSTAGE; k++) begin
            ent_d[k]      = ent_q[k-1];
            ent_d[k].tnew = tnew_dec(ent_q[k-1].tnew);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                ent_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                ent_q[k] <= ent_d[k];
            end
        end
    end

    md_busy_counter #(
        .MD_LAT (MD_LAT)
    ) u_md (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (hz.d_md_start && !stall),
        .busy_o  (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: driver pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NSTAGE = 3;
    localparam int MD_LAT = 5;
    localparam int NONE   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NSTAGE(NSTAGE)) hz ();

    hazard_scoreboard #(
        .NSTAGE (NSTAGE),
        .MD_LAT (MD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        int cyc;
        bit stall;
        int rs_sel;
        int rt_sel;
        bit busy;
    } exp_t;

    // In-flight writer: age 0 = E, age a = stage a.
    typedef struct {
        int dst;
        int tnew0;
        int age;
    } wr_t;

    exp_t expq [$];
    wr_t  wr [$];
    int   md_left = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input int c, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, c, got, exp);
        end
    endtask

    function automatic void eval_op(input int r, input int tuse,
                                    output bit st, output int sel);
        int best;
        int cur;
        best = -1;
        st = 0;
        sel = 0;
        for (int i = 0; i < wr.size(); i++) begin
            if (r != 0 && wr[i].dst == r) begin
                if (best < 0 || wr[i].age < wr[best].age) best = i;
            end
        end
        if (best >= 0) begin
            cur = wr[best].tnew0 - wr[best].age;
            if (cur < 0) cur = 0;
            st = (tuse != NONE) && (cur > tuse);
            sel = (cur == 0) ? wr[best].age + 1 : 0;
        end
    endfunction

    task automatic step(input int rs, input int rt,
                        input int tus, input int tut,
                        input int dst, input int wen, input int tnew,
                        input int ms, input int mu, input bit rst);
        exp_t e;
        bit st_rs, st_rt;
        wr_t n;
        @(posedge clk);
        #1;
        cyc++;
        reset        = rst;
        hz.d_rs      = REG_AW'(rs);
        hz.d_rt      = REG_AW'(rt);
        hz.d_tuse_rs = T_W'(tus);
        hz.d_tuse_rt = T_W'(tut);
        hz.d_dst     = REG_AW'(dst);
        hz.d_wen     = wen[0];
        hz.d_tnew    = T_W'(tnew);
        hz.d_md_start = ms[0];
        hz.d_md_use  = mu[0];
        eval_op(rs, tus, st_rs, e.rs_sel);
        eval_op(rt, tut, st_rt, e.rt_sel);
        e.busy  = (md_left > 0);
        e.stall = st_rs || st_rt || (mu != 0 && e.busy);
        e.cyc   = cyc;
        expq.push_back(e);
        // Advance the model to the state after the coming edge.
        if (rst) begin
            wr.delete();
            md_left = 0;
        end else begin
            for (int i = wr.size() - 1; i >= 0; i--) begin
                wr[i].age++;
                if (wr[i].age >= NSTAGE) wr.delete(i);
            end
            if (!e.stall && wen != 0 && dst != 0) begin
                n.dst = dst;
                n.tnew0 = tnew;
                n.age = 0;
                wr.push_back(n);
            end
            if (ms != 0 && !e.stall) md_left = MD_LAT;
            else if (md_left > 0) md_left--;
        end
    endtask

    task automatic nop();
        step(0, 0, NONE, NONE, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("stall", e.cyc, int'(hz.stall), int'(e.stall));
            chk("fwd_rs_sel", e.cyc, int'(hz.fwd_rs_sel), e.rs_sel);
            chk("fwd_rt_sel", e.cyc, int'(hz.fwd_rt_sel), e.rt_sel);
            chk("md_busy", e.cyc, int'(hz.md_busy), int'(e.busy));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        hz.d_rs = '0;
        hz.d_rt = '0;
        hz.d_tuse_rs = '1;
        hz.d_tuse_rt = '1;
        hz.d_dst = '0;
        hz.d_wen = 1'b0;
        hz.d_tnew = '0;
        hz.d_md_start = 1'b0;
        hz.d_md_use = 1'b0;
        repeat (3) @(posedge clk);

        // Post-reset state.
        nop();
        // lw $1 then addu $2,$1 (tuse_rs=1): stall once, then issue.
        step(0, 0, NONE, NONE, 1, 1, 2, 0, 0, 0);
        step(1, 0, 1, NONE, 2, 1, 1, 0, 0, 0);
        step(1, 0, 1, NONE, 2, 1, 1, 0, 0, 0);
        step(1, 0, 1, NONE, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, NONE, 0, 0, 0, 0, 0, 0);
        // ori $3 then beq $3 (tuse=0).
        step(0, 0, NONE, NONE, 3, 1, 1, 0, 0, 0);
        step(3, 0, 0, NONE, 0, 0, 0, 0, 0, 0);
        step(3, 0, 0, NONE, 0, 0, 0, 0, 0, 0);
        // Two writers to $4, youngest forwards; rs==rt.
        step(0, 0, NONE, NONE, 4, 1, 0, 0, 0, 0);
        step(0, 0, NONE, NONE, 4, 1, 0, 0, 0, 0);
        step(4, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        // $0 destination never forwards or stalls.
        step(0, 0, NONE, NONE, 0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Mul/div start then mfhi held in D.
        step(0, 0, NONE, NONE, 0, 0, 0, 1, 1, 0);
        repeat (7) step(0, 0, NONE, NONE, 5, 1, 1, 0, 1, 0);
        // Start under stall is dropped.
        step(0, 0, NONE, NONE, 6, 1, 3, 0, 0, 0);
        step(6, 0, 0, NONE, 0, 0, 0, 1, 1, 0);
        // Reset mid-flight with lw in E and busy count.
        step(0, 0, NONE, NONE, 0, 0, 0, 1, 1, 0);
        nop();
        step(0, 0, NONE, NONE, 1, 1, 2, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        // TUSE_NONE with a tnew=2 match.
        step(0, 0, NONE, NONE, 5, 1, 2, 0, 0, 0);
        step(5, 0, NONE, NONE, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 4), $urandom_range(0, 1),
                 $urandom_range(0, 3),
                 ($urandom_range(0, 9) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
        end

        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
